// File: rtl/mmio_uart_tx.sv
// MMIO byte sink: buffers store data in a small FIFO and sends it LSB-first as 8N1 frames on tx.
// Define MMIO_UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module mmio_uart_tx #(
   parameter int CLOCKS_PER_BIT  = 104,
   parameter int FIFO_DEPTH_LOG2 = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     io_write_valid,
   input  logic [7:0]               io_write_data,
   output logic                     io_write_ready,
   output logic                     tx,
   output logic                     busy,
   output logic [FIFO_DEPTH_LOG2:0] fifo_count
);
   localparam int DEPTH  = 1 << FIFO_DEPTH_LOG2;
   localparam int CNT_W  = FIFO_DEPTH_LOG2 + 1;
   localparam int BAUD_W = $clog2(CLOCKS_PER_BIT);

   localparam logic [BAUD_W-1:0]          BAUD_ZERO  = BAUD_W'(0);
   localparam logic [BAUD_W-1:0]          BAUD_ONE   = BAUD_W'(1);
   localparam logic [BAUD_W-1:0]          BAUD_LAST  = BAUD_W'(CLOCKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0]           CNT_ZERO   = CNT_W'(0);
   localparam logic [CNT_W-1:0]           CNT_ONE    = CNT_W'(1);
   localparam logic [CNT_W-1:0]           CNT_FULL   = CNT_W'(DEPTH);
   localparam logic [FIFO_DEPTH_LOG2-1:0] PTR_ZERO   = FIFO_DEPTH_LOG2'(0);
   localparam logic [FIFO_DEPTH_LOG2-1:0] PTR_ONE    = FIFO_DEPTH_LOG2'(1);

`ifdef MMIO_UART_TX_PARITY_EN
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   function automatic logic even_parity(input logic [7:0] data);
      return ^data;
   endfunction

   logic parity_bit;
`else
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;
`endif

   state_t                     state;
   logic [7:0]                 mem [DEPTH];
   logic [FIFO_DEPTH_LOG2-1:0] wr_ptr;
   logic [FIFO_DEPTH_LOG2-1:0] rd_ptr;
   logic [7:0]                 shift;
   logic [2:0]                 bit_idx;
   logic [BAUD_W-1:0]          baud;
   logic                       push;
   logic                       pop;
   logic                       bit_done;
   logic [7:0]                 head;

   assign io_write_ready = (fifo_count != CNT_FULL);
   assign busy           = (state != IDLE) || (fifo_count != CNT_ZERO);
   assign push           = io_write_valid && io_write_ready;
   assign bit_done       = (baud == BAUD_LAST);
   assign head           = mem[rd_ptr];

   // The transmitter takes the head byte when idle, or back-to-back at the end of a stop bit.
   always_comb begin
      pop = 1'b0;
      if (fifo_count == CNT_ZERO) begin
         pop = 1'b0;
      end else if (state == IDLE) begin
         pop = 1'b1;
      end else if ((state == STOP) && bit_done) begin
         pop = 1'b1;
      end else begin
         pop = 1'b0;
      end
   end

   // FIFO storage; contents need no reset because occupancy gates every read.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= io_write_data;
      end
   end

   // FIFO pointers and occupancy.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr     <= PTR_ZERO;
         rd_ptr     <= PTR_ZERO;
         fifo_count <= CNT_ZERO;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + CNT_ONE;
            2'b01:   fifo_count <= fifo_count - CNT_ONE;
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   // Frame sequencer; tx is driven only from here so the line never glitches.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         tx      <= 1'b1;
         shift   <= 8'h00;
         bit_idx <= 3'd0;
         baud    <= BAUD_ZERO;
`ifdef MMIO_UART_TX_PARITY_EN
         parity_bit <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               baud <= BAUD_ZERO;
               tx   <= 1'b1;
               if (pop) begin
                  shift <= head;
`ifdef MMIO_UART_TX_PARITY_EN
                  parity_bit <= even_parity(head);
`endif
                  tx    <= 1'b0;
                  state <= START;
               end
            end
            START: begin
               if (bit_done) begin
                  baud    <= BAUD_ZERO;
                  bit_idx <= 3'd0;
                  tx      <= shift[0];
                  state   <= DATA;
               end else begin
                  baud <= baud + BAUD_ONE;
               end
            end
            DATA: begin
               if (bit_done) begin
                  baud <= BAUD_ZERO;
                  if (bit_idx == 3'd7) begin
`ifdef MMIO_UART_TX_PARITY_EN
                     tx    <= parity_bit;
                     state <= PARITY;
`else
                     tx    <= 1'b1;
                     state <= STOP;
`endif
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                     shift   <= {1'b0, shift[7:1]};
                     tx      <= shift[1];
                  end
               end else begin
                  baud <= baud + BAUD_ONE;
               end
            end
`ifdef MMIO_UART_TX_PARITY_EN
            PARITY: begin
               if (bit_done) begin
                  baud  <= BAUD_ZERO;
                  tx    <= 1'b1;
                  state <= STOP;
               end else begin
                  baud <= baud + BAUD_ONE;
               end
            end
`endif
            STOP: begin
               if (bit_done) begin
                  baud <= BAUD_ZERO;
                  if (pop) begin
                     shift <= head;
`ifdef MMIO_UART_TX_PARITY_EN
                     parity_bit <= even_parity(head);
`endif
                     tx    <= 1'b0;
                     state <= START;
                  end else begin
                     tx    <= 1'b1;
                     state <= IDLE;
                  end
               end else begin
                  baud <= baud + BAUD_ONE;
               end
            end
            default: begin
               baud  <= BAUD_ZERO;
               tx    <= 1'b1;
               state <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: a frame-schedule model checked every cycle plus directed literal checks.
module tb_mmio_uart_tx;
   localparam int CPB   = 4;
   localparam int LOG2  = 2;
   localparam int DEPTH = 4;
`ifdef MMIO_UART_TX_PARITY_EN
   localparam int NBITS = 11;
`else
   localparam int NBITS = 10;
`endif
   localparam int FRAME = NBITS * CPB;
   localparam int MAXACC = 256;

   logic          clk            = 1'b0;
   logic          reset          = 1'b1;
   logic          io_write_valid = 1'b0;
   logic [7:0]    io_write_data  = 8'h00;
   logic          io_write_ready;
   logic          tx;
   logic          busy;
   logic [LOG2:0] fifo_count;

   int checks   = 0;
   int failures = 0;

   mmio_uart_tx #(.CLOCKS_PER_BIT(CPB), .FIFO_DEPTH_LOG2(LOG2)) dut (
      .clk            (clk),
      .reset          (reset),
      .io_write_valid (io_write_valid),
      .io_write_data  (io_write_data),
      .io_write_ready (io_write_ready),
      .tx             (tx),
      .busy           (busy),
      .fifo_count     (fifo_count)
   );

   always #5 clk = ~clk;

   // Model: every accepted byte gets a frame start time; outputs follow from that schedule.
   int         t = 0;
   int         n_acc = 0;
   int         acc_edge [MAXACC];
   int         start_t  [MAXACC];
   logic [7:0] acc_data [MAXACC];

   function automatic int model_count(input int tt);
      int c = 0;
      for (int k = 0; k < n_acc; k++) begin
         if (acc_edge[k] <= tt) c++;
         if (start_t[k] <= tt) c--;
      end
      return c;
   endfunction

   function automatic logic frame_bit(input logic [7:0] d, input int b);
      if (b == 0) return 1'b0;
      if (b <= 8) return d[b-1];
      if (b == NBITS - 1) return 1'b1;
      return ^d;
   endfunction

   function automatic logic model_tx(input int tt);
      for (int k = 0; k < n_acc; k++)
         if (tt >= start_t[k] && tt < start_t[k] + FRAME)
            return frame_bit(acc_data[k], (tt - start_t[k]) / CPB);
      return 1'b1;
   endfunction

   function automatic logic model_active(input int tt);
      for (int k = 0; k < n_acc; k++)
         if (tt >= start_t[k] && tt < start_t[k] + FRAME) return 1'b1;
      return 1'b0;
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         n_acc = 0;
      end else begin
         t = t + 1;
         if (io_write_valid && model_count(t - 1) != DEPTH && n_acc < MAXACC) begin
            acc_edge[n_acc] = t;
            acc_data[n_acc] = io_write_data;
            if (n_acc == 0 || t + 1 > start_t[n_acc-1] + FRAME) start_t[n_acc] = t + 1;
            else start_t[n_acc] = start_t[n_acc-1] + FRAME;
            n_acc = n_acc + 1;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0d)", name, actual, expected, t);
      end
   endtask

   always @(negedge clk) begin
      if (!reset) begin
         check("model_tx", tx, model_tx(t));
         check("model_count", fifo_count, model_count(t));
         check("model_ready", io_write_ready, model_count(t) != DEPTH);
         check("model_busy", busy, model_active(t) || (model_count(t) != 0));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(input int limit);
      int n = 0;
      while (busy && n < limit) begin
         step();
         n++;
      end
      check("idle_timeout", busy, 1'b0);
   endtask

   logic seq_tx   [0:48];
   logic seq_busy [0:48];

   task automatic send_and_record(input logic [7:0] d);
      io_write_valid = 1'b1;
      io_write_data  = d;
      step();
      io_write_valid = 1'b0;
      check("rec_count_e0", fifo_count, 1);
      for (int i = 1; i <= 48; i++) begin
         step();
         seq_tx[i]   = tx;
         seq_busy[i] = busy;
      end
   endtask

   initial begin
      repeat (3) step();
      check("rst_tx", tx, 1'b1);
      check("rst_count", fifo_count, 0);
      check("rst_ready", io_write_ready, 1'b1);
      check("rst_busy", busy, 1'b0);
      reset = 1'b0;
      repeat (2) step();

      // Single byte 0xA5: start 0, data 1,0,1,0,0,1,0,1, stop 1.
      send_and_record(8'hA5);
      check("a5_start", seq_tx[1], 1'b0);
      check("a5_start_end", seq_tx[4], 1'b0);
      check("a5_bit0", seq_tx[5], 1'b1);
      check("a5_bit0_end", seq_tx[8], 1'b1);
      check("a5_bit1", seq_tx[9], 1'b0);
      check("a5_bit2", seq_tx[13], 1'b1);
      check("a5_bit4", seq_tx[21], 1'b0);
      check("a5_bit7", seq_tx[33], 1'b1);
`ifdef MMIO_UART_TX_PARITY_EN
      check("a5_parity", seq_tx[37], 1'b0);
      check("a5_busy_e44", seq_busy[44], 1'b1);
      check("a5_busy_e45", seq_busy[45], 1'b0);
`else
      check("a5_stop", seq_tx[37], 1'b1);
      check("a5_busy_e40", seq_busy[40], 1'b1);
      check("a5_busy_e41", seq_busy[41], 1'b0);
`endif
      wait_idle(200);

      // Back-pressure: 0x01..0x06 on consecutive edges, 0x06 refused.
      for (int i = 0; i < 6; i++) begin
         io_write_valid = 1'b1;
         io_write_data  = 8'(i + 1);
         if (i == 5) check("bp_ready_full", io_write_ready, 1'b0);
         step();
         if (i >= 4) check("bp_count_full", fifo_count, 4);
      end
      io_write_valid = 1'b0;
      repeat (FRAME - 5) step();
      check("bp_stop_last", tx, 1'b1);
      check("bp_count_pre", fifo_count, 4);
      step();
      check("bp_b2b_start", tx, 1'b0);
      check("bp_count_post", fifo_count, 3);
      wait_idle(400);

      // Simultaneous push/pop at the edge where the stop bit ends.
      io_write_valid = 1'b1;
      io_write_data  = 8'h3C;
      step();
      io_write_data  = 8'hC3;
      step();
      io_write_valid = 1'b0;
      check("sim_count_e1", fifo_count, 1);
      check("sim_tx_e1", tx, 1'b0);
      repeat (FRAME - 1) step();
      check("sim_count_efr", fifo_count, 1);
      check("sim_tx_efr", tx, 1'b1);
      io_write_valid = 1'b1;
      io_write_data  = 8'h5A;
      step();
      io_write_valid = 1'b0;
      check("sim_count_same", fifo_count, 1);
      check("sim_tx_start", tx, 1'b0);
      wait_idle(400);

`ifdef MMIO_UART_TX_PARITY_EN
      send_and_record(8'h07);
      check("p07_bit7", seq_tx[33], 1'b0);
      check("p07_parity", seq_tx[37], 1'b1);
      check("p07_stop", seq_tx[41], 1'b1);
      check("p07_busy_e44", seq_busy[44], 1'b1);
      check("p07_busy_e45", seq_busy[45], 1'b0);
      wait_idle(200);
      send_and_record(8'h03);
      check("p03_parity", seq_tx[37], 1'b0);
      check("p03_stop", seq_tx[41], 1'b1);
      wait_idle(200);
`endif

      // Reset during a low data bit of 0x55, with 0x66 still queued.
      io_write_valid = 1'b1;
      io_write_data  = 8'h55;
      step();
      io_write_data  = 8'h66;
      step();
      io_write_valid = 1'b0;
      repeat (9) step();
      check("mid_tx_low", tx, 1'b0);
      check("mid_count", fifo_count, 1);
      #2;
      reset = 1'b1;
      #1;
      check("mid_rst_tx", tx, 1'b1);
      check("mid_rst_count", fifo_count, 0);
      check("mid_rst_ready", io_write_ready, 1'b1);
      check("mid_rst_busy", busy, 1'b0);
      repeat (2) step();
      reset = 1'b0;
      for (int i = 0; i < 100; i++) begin
         step();
         check("post_rst_tx", tx, 1'b1);
      end
      check("post_rst_busy", busy, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
